time_counter: RTL and testbench



---
 rtl/time_counter.sv | 140 ++++++++++++++
 tb/tb_time_counter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// 24-hour HH:MM wall-time keeper: four BCD digit counters advanced by one_minute, loadable from the alarm controller.
// Optional seconds digits (BCD 00..59 on one_second) are built only when TC_SECONDS_EN is defined.
module time_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_minute,
  input  logic       one_second,
  input  logic       load_new_c,
  input  logic [3:0] new_current_time_ms_hr,
  input  logic [3:0] new_current_time_ls_hr,
  input  logic [3:0] new_current_time_ms_min,
  input  logic [3:0] new_current_time_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
`ifdef TC_SECONDS_EN
  output logic [3:0] current_time_ms_sec,
  output logic [3:0] current_time_ls_sec,
`endif
  output logic       day_rollover,
  output logic       load_error
);

  logic       load_valid;
  logic [3:0] ms_hr_nxt;
  logic [3:0] ls_hr_nxt;
  logic [3:0] ms_min_nxt;
  logic [3:0] ls_min_nxt;
  logic       rollover_nxt;
  logic       error_nxt;

  // Hours 00..23 and minutes 00..59, each digit a legal BCD value.
  always_comb begin
    load_valid = (new_current_time_ls_min <= 4'd9) &&
                 (new_current_time_ms_min <= 4'd5) &&
                 (new_current_time_ls_hr  <= 4'd9) &&
                 ((new_current_time_ms_hr < 4'd2) ||
                  ((new_current_time_ms_hr == 4'd2) && (new_current_time_ls_hr <= 4'd3)));
  end

  always_comb begin
    ms_hr_nxt    = current_time_ms_hr;
    ls_hr_nxt    = current_time_ls_hr;
    ms_min_nxt   = current_time_ms_min;
    ls_min_nxt   = current_time_ls_min;
    rollover_nxt = 1'b0;
    error_nxt    = 1'b0;
    if (load_new_c) begin
      if (load_valid) begin
        ms_hr_nxt  = new_current_time_ms_hr;
        ls_hr_nxt  = new_current_time_ls_hr;
        ms_min_nxt = new_current_time_ms_min;
        ls_min_nxt = new_current_time_ls_min;
      end else begin
        error_nxt = 1'b1;
      end
    end else if (one_minute) begin
      if (current_time_ls_min == 4'd9) begin
        ls_min_nxt = 4'd0;
        if (current_time_ms_min == 4'd5) begin
          ms_min_nxt = 4'd0;
          // Units of hours wrap after 3 only in the twenties.
          if ((current_time_ms_hr == 4'd2) && (current_time_ls_hr == 4'd3)) begin
            ms_hr_nxt    = 4'd0;
            ls_hr_nxt    = 4'd0;
            rollover_nxt = 1'b1;
          end else if (current_time_ls_hr == 4'd9) begin
            ls_hr_nxt = 4'd0;
            ms_hr_nxt = current_time_ms_hr + 4'd1;
          end else begin
            ls_hr_nxt = current_time_ls_hr + 4'd1;
          end
        end else begin
          ms_min_nxt = current_time_ms_min + 4'd1;
        end
      end else begin
        ls_min_nxt = current_time_ls_min + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      current_time_ms_hr  <= 4'd0;
      current_time_ls_hr  <= 4'd0;
      current_time_ms_min <= 4'd0;
      current_time_ls_min <= 4'd0;
      day_rollover        <= 1'b0;
      load_error          <= 1'b0;
    end else begin
      current_time_ms_hr  <= ms_hr_nxt;
      current_time_ls_hr  <= ls_hr_nxt;
      current_time_ms_min <= ms_min_nxt;
      current_time_ls_min <= ls_min_nxt;
      day_rollover        <= rollover_nxt;
      load_error          <= error_nxt;
    end
  end

`ifdef TC_SECONDS_EN
  logic [3:0] ms_sec_nxt;
  logic [3:0] ls_sec_nxt;

  // Seconds are free-running and never carry into minutes; any load restarts them.
  always_comb begin
    ms_sec_nxt = current_time_ms_sec;
    ls_sec_nxt = current_time_ls_sec;
    if (load_new_c) begin
      ms_sec_nxt = 4'd0;
      ls_sec_nxt = 4'd0;
    end else if (one_second) begin
      if (current_time_ls_sec == 4'd9) begin
        ls_sec_nxt = 4'd0;
        if (current_time_ms_sec == 4'd5) begin
          ms_sec_nxt = 4'd0;
        end else begin
          ms_sec_nxt = current_time_ms_sec + 4'd1;
        end
      end else begin
        ls_sec_nxt = current_time_ls_sec + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      current_time_ms_sec <= 4'd0;
      current_time_ls_sec <= 4'd0;
    end else begin
      current_time_ms_sec <= ms_sec_nxt;
      current_time_ls_sec <= ls_sec_nxt;
    end
  end
`else
  logic unused_one_second;
  assign unused_one_second = one_second;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: directed scenarios plus randomized traffic against a minutes-of-day model.
module tb_time_counter;

  logic       clock;
  logic       reset;
  logic       one_minute;
  logic       one_second;
  logic       load_new_c;
  logic [3:0] nms_hr, nls_hr, nms_min, nls_min;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       day_rollover;
  logic       load_error;
`ifdef TC_SECONDS_EN
  logic [3:0] ms_sec, ls_sec;
`endif

  time_counter dut (
    .clock                   (clock),
    .reset                   (reset),
    .one_minute              (one_minute),
    .one_second              (one_second),
    .load_new_c              (load_new_c),
    .new_current_time_ms_hr  (nms_hr),
    .new_current_time_ls_hr  (nls_hr),
    .new_current_time_ms_min (nms_min),
    .new_current_time_ls_min (nls_min),
    .current_time_ms_hr      (ms_hr),
    .current_time_ls_hr      (ls_hr),
    .current_time_ms_min     (ms_min),
    .current_time_ls_min     (ls_min),
`ifdef TC_SECONDS_EN
    .current_time_ms_sec     (ms_sec),
    .current_time_ls_sec     (ls_sec),
`endif
    .day_rollover            (day_rollover),
    .load_error              (load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vecs = 0;
  int errs = 0;

  // Reference model: time as minutes since midnight, seconds as 0..59.
  int   m_time = 0;
  int   m_sec  = 0;
  logic m_roll = 1'b0;
  logic m_err  = 1'b0;

`ifdef TC_SECONDS_EN
  wire [25:0] act = {ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec, day_rollover, load_error};
  function automatic logic [25:0] exp_vec();
    int hh, mm;
    hh = m_time / 60;
    mm = m_time % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
            4'(m_sec / 10), 4'(m_sec % 10), m_roll, m_err};
  endfunction
`else
  wire [17:0] act = {ms_hr, ls_hr, ms_min, ls_min, day_rollover, load_error};
  function automatic logic [17:0] exp_vec();
    int hh, mm;
    hh = m_time / 60;
    mm = m_time % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), m_roll, m_err};
  endfunction
`endif

  function automatic logic [15:0] hhmm(input int hh, input int mm);
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model at the rising edge.
  task automatic step(input logic lc, input logic om, input logic os, input logic [15:0] d);
    int hh, mm;
    @(negedge clock);
    load_new_c = lc;
    one_minute = om;
    one_second = os;
    {nms_hr, nls_hr, nms_min, nls_min} = d;
    @(posedge clock);
    if (!reset) begin
      m_time = 0; m_sec = 0; m_roll = 1'b0; m_err = 1'b0;
    end else begin
      m_roll = 1'b0;
      m_err  = 1'b0;
      if (lc) begin
        hh = int'(d[15:12]) * 10 + int'(d[11:8]);
        mm = int'(d[7:4]) * 10 + int'(d[3:0]);
        if (d[11:8] <= 4'd9 && d[3:0] <= 4'd9 && hh < 24 && mm < 60) m_time = hh * 60 + mm;
        else m_err = 1'b1;
        m_sec = 0;
      end else begin
        if (om) begin
          m_time = (m_time + 1) % 1440;
          m_roll = (m_time == 0);
        end
        if (os) m_sec = (m_sec + 1) % 60;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0);
      vecs++;
      if (act !== exp_vec()) begin
        errs++;
        $display("FAIL reset_hold: got %h expected %h", act, exp_vec());
      end
    end
    @(negedge clock);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h0);
    vecs++;
    if (act !== exp_vec() || act !== '0) begin
      errs++;
      $display("FAIL reset_release: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_count();
    step(1'b1, 1'b0, 1'b0, hhmm(12, 34));
    for (int i = 0; i < 28; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      vecs++;
      if (act !== exp_vec()) begin
        errs++;
        $display("FAIL count_12_34 tick %0d: got %h expected %h", i, act, exp_vec());
      end
      step(1'b0, 1'b0, 1'b0, 16'h0);
    end
    vecs++;
    if ({ms_hr, ls_hr, ms_min, ls_min} !== 16'h1302) begin
      errs++;
      $display("FAIL count_end: got %h expected 1302", {ms_hr, ls_hr, ms_min, ls_min});
    end
  endtask

  task automatic test_rollover();
    logic [15:0] starts [3];
    starts = '{hhmm(23, 58), hhmm(9, 59), hhmm(19, 59)};
    for (int s = 0; s < 3; s++) begin
      step(1'b1, 1'b0, 1'b0, starts[s]);
      for (int i = 0; i < 3; i++) begin
        step(1'b0, (i < 2), 1'b0, 16'h0);
        vecs++;
        if (act !== exp_vec()) begin
          errs++;
          $display("FAIL rollover start %h cyc %0d: got %h expected %h", starts[s], i, act, exp_vec());
        end
      end
    end
    step(1'b1, 1'b0, 1'b0, hhmm(23, 59));
    step(1'b0, 1'b1, 1'b0, 16'h0);
    vecs++;
    if (day_rollover !== 1'b1 || {ms_hr, ls_hr, ms_min, ls_min} !== 16'h0000) begin
      errs++;
      $display("FAIL day_rollover_pulse: got %b/%h expected 1/0000", day_rollover,
               {ms_hr, ls_hr, ms_min, ls_min});
    end
  endtask

  task automatic test_load_errors();
    logic [15:0] bad [3];
    bad = '{16'h2400, 16'h1960, 16'h0A00};
    step(1'b1, 1'b0, 1'b0, hhmm(11, 11));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, bad[i]);
      vecs++;
      if (act !== exp_vec() || load_error !== 1'b1) begin
        errs++;
        $display("FAIL bad_load %h: got %h expected %h", bad[i], act, exp_vec());
      end
      step(1'b0, 1'b0, 1'b0, 16'h0);
      vecs++;
      if (act !== exp_vec() || load_error !== 1'b0) begin
        errs++;
        $display("FAIL bad_load_clear %h: got %h expected %h", bad[i], act, exp_vec());
      end
    end
    step(1'b1, 1'b1, 1'b0, hhmm(11, 22));
    vecs++;
    if ({ms_hr, ls_hr, ms_min, ls_min} !== 16'h1122 || act !== exp_vec()) begin
      errs++;
      $display("FAIL load_drops_tick: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 1'b0, hhmm(7, 45));
    step(1'b0, 1'b1, 1'b0, 16'h0);
    @(negedge clock);
    load_new_c = 1'b0; one_minute = 1'b0; one_second = 1'b0;
    #2 reset = 1'b0;
    m_time = 0; m_sec = 0; m_roll = 1'b0; m_err = 1'b0;
    #1;
    vecs++;
    if (act !== exp_vec()) begin
      errs++;
      $display("FAIL async_reset: got %h expected %h", act, exp_vec());
    end
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0, 16'h0);
    vecs++;
    if (act !== exp_vec()) begin
      errs++;
      $display("FAIL first_tick_after_reset: got %h expected %h", act, exp_vec());
    end
  endtask

`ifdef TC_SECONDS_EN
  task automatic test_seconds();
    step(1'b1, 1'b0, 1'b0, hhmm(0, 0));
    for (int i = 0; i < 61; i++) step(1'b0, 1'b0, 1'b1, 16'h0);
    vecs++;
    if ({ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec} !== 24'h000001 || act !== exp_vec()) begin
      errs++;
      $display("FAIL seconds_61: got %h expected %h", act, exp_vec());
    end
    step(1'b1, 1'b0, 1'b1, 16'hFF00);
    vecs++;
    if ({ms_sec, ls_sec} !== 8'h00 || act !== exp_vec()) begin
      errs++;
      $display("FAIL seconds_load_clear: got %h expected %h", act, exp_vec());
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] d;
    logic lc, om, os;
    for (int i = 0; i < 2000; i++) begin
      lc = ($urandom_range(0, 15) == 0);
      om = ($urandom_range(0, 3) != 0);
      os = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) d = hhmm($urandom_range(0, 23), $urandom_range(0, 59));
      else d = 16'($urandom);
      step(lc, om, os, d);
      vecs++;
      if (act !== exp_vec()) begin
        errs++;
        $display("FAIL random cyc %0d: got %h expected %h", i, act, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    load_new_c = 1'b0; one_minute = 1'b0; one_second = 1'b0;
    nms_hr = 4'd0; nls_hr = 4'd0; nms_min = 4'd0; nls_min = 4'd0;
    test_reset();
    test_count();
    test_rollover();
    test_load_errors();
    test_async_reset();
`ifdef TC_SECONDS_EN
    test_seconds();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
